controle_execucao: RTL and testbench

Run/halt/step sequencer for the single-cycle RISC-V core. Produces one commit-enable, `habilita`. Top-level glue gates the PC update (gerencia_PC), regWrite and MemWrite with `habilita`, so the core advances exactly one instruction per enabled cycle. Provides a PC breakpoint, EBREAK halt, an N-instruction step mode and a retired-instruction counter for the debug top level.

---
 rtl/controle_execucao_pkg.sv | 34 +++
 rtl/controle_execucao_contador_passos.sv | 37 +++
 rtl/controle_execucao.sv | 151 +++++++++++++++
 tb/tb_controle_execucao.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_execucao_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pkg_controle_execucao
// Purpose  : Shared state codes, halt-cause codes and constants for the
//            run/halt/step sequencer of the single-cycle RISC-V core.
// Revision : 1.0 - initial release
// ============================================================================
package pkg_controle_execucao;

  // Sequencer states; the fourth 2-bit code is illegal and recovers to PARADO.
  typedef enum logic [1:0] {
    ESTADO_PARADO     = 2'd0,
    ESTADO_EXECUTANDO = 2'd1,
    ESTADO_PASSO      = 2'd2
  } estado_t;

  // Reason for the most recent halt, visible to the debug top level.
  typedef enum logic [2:0] {
    CAUSA_RESET      = 3'd0,
    CAUSA_COMANDO    = 3'd1,
    CAUSA_BREAKPOINT = 3'd2,
    CAUSA_FIM_PASSO  = 3'd3,
    CAUSA_EBREAK     = 3'd4
  } causa_t;

  localparam logic [31:0] INST_EBREAK = 32'h00100073;

  // A step request of zero instructions still executes one instruction.
  function automatic logic [15:0] carga_passos(input logic [15:0] pedido);
    return (pedido == 16'd0) ? 16'd1 : pedido;
  endfunction

endpackage
`default_nettype wire

// File: rtl/controle_execucao_contador_passos.sv
`default_nettype none
// ============================================================================
// Module   : contador_passos
// Purpose  : 16-bit loadable down-counter holding the remaining instructions
//            of a step request.
// Ports    : clk, rst     - clock, asynchronous active-high reset
//            load, valor  - load the count with valor (load wins over dec)
//            dec          - decrement on a committed step instruction
//            ultimo       - high while the count equals one
// Revision : 1.0 - initial release
// ============================================================================
module contador_passos (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] valor,
  input  logic        dec,
  output logic        ultimo
);

  logic [15:0] r_contagem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_contagem <= 16'd0;
    end else if (load) begin
      r_contagem <= valor;
    end else if (dec && (r_contagem != 16'd0)) begin
      // Never wraps below zero, so a stale decrement cannot re-arm ultimo.
      r_contagem <= r_contagem - 16'd1;
    end
  end

  assign ultimo = (r_contagem == 16'd1);

endmodule
`default_nettype wire

// File: rtl/controle_execucao.sv
`default_nettype none
// ============================================================================
// Module   : controle_execucao
// Purpose  : Run/halt/step sequencer for the single-cycle RISC-V core. Drives
//            a single commit enable (habilita) that the top level uses to
//            gate the PC update, regWrite and MemWrite. Adds a PC breakpoint,
//            EBREAK halt, N-instruction step mode and a retired counter.
// Ports    : clk, rst             - clock, asynchronous active-high reset
//            cmd_run/halt/step    - one-cycle command pulses
//            passos               - step count, sampled with cmd_step
//            bp_en, bp_addr       - PC breakpoint
//            atualPC, inst        - current PC and instruction
//            habilita             - commit current instruction (same cycle)
//            parado               - registered "in PARADO" flag
//            causa                - last halt cause
//            instr_retiradas      - committed-instruction count (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module controle_execucao
  import pkg_controle_execucao::*;
#(
  parameter int LARGURA_CONT      = 32,
  parameter bit PARAR_EBREAK      = 1'b1,
  parameter bit INICIA_EXECUTANDO = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_run,
  input  logic                    cmd_halt,
  input  logic                    cmd_step,
  input  logic [15:0]             passos,
  input  logic                    bp_en,
  input  logic [31:0]             bp_addr,
  input  logic [31:0]             atualPC,
  input  logic [31:0]             inst,
  output logic                    habilita,
  output logic                    parado,
  output logic [2:0]              causa,
  output logic [LARGURA_CONT-1:0] instr_retiradas
);

  localparam estado_t c_ESTADO_RESET =
    INICIA_EXECUTANDO ? ESTADO_EXECUTANDO : ESTADO_PARADO;

  estado_t                 r_estado;
  causa_t                  r_causa;
  logic                    r_parado;
  logic                    r_ignora_bp;
  logic [LARGURA_CONT-1:0] r_instr_retiradas;

  logic w_em_execucao;
  logic w_bp_hit;
  logic w_eb;
  logic w_habilita;
  logic w_carga_passos;
  logic w_dec_passos;
  logic w_ultimo;

  assign w_em_execucao = (r_estado == ESTADO_EXECUTANDO) || (r_estado == ESTADO_PASSO);

  // ignora_bp lets the instruction sitting on the breakpoint PC execute once
  // after a resume instead of halting again immediately.
  assign w_bp_hit = bp_en && (atualPC == bp_addr) && !r_ignora_bp;
  assign w_eb     = PARAR_EBREAK && (inst == INST_EBREAK);

  // rst is folded in so a reset state of EXECUTANDO still cannot commit
  // while reset is held.
  assign w_habilita = !rst && w_em_execucao && !cmd_halt && !w_bp_hit;

  assign w_carga_passos = (r_estado == ESTADO_PARADO) && !cmd_halt && cmd_step;
  assign w_dec_passos   = w_habilita && (r_estado == ESTADO_PASSO);

  contador_passos u_contador_passos (
    .clk    (clk),
    .rst    (rst),
    .load   (w_carga_passos),
    .valor  (carga_passos(passos)),
    .dec    (w_dec_passos),
    .ultimo (w_ultimo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado    <= c_ESTADO_RESET;
      r_parado    <= !INICIA_EXECUTANDO;
      r_causa     <= CAUSA_RESET;
      r_ignora_bp <= 1'b0;
    end else begin
      case (r_estado)
        ESTADO_PARADO: begin
          // cmd_halt has top priority and is a no-op while stopped.
          if (!cmd_halt) begin
            if (cmd_step) begin
              r_estado    <= ESTADO_PASSO;
              r_parado    <= 1'b0;
              r_ignora_bp <= 1'b1;
            end else if (cmd_run) begin
              r_estado    <= ESTADO_EXECUTANDO;
              r_parado    <= 1'b0;
              r_ignora_bp <= 1'b1;
            end
          end
        end

        ESTADO_EXECUTANDO, ESTADO_PASSO: begin
          if (cmd_halt) begin
            r_estado <= ESTADO_PARADO;
            r_parado <= 1'b1;
            r_causa  <= CAUSA_COMANDO;
          end else if (w_bp_hit) begin
            r_estado <= ESTADO_PARADO;
            r_parado <= 1'b1;
            r_causa  <= CAUSA_BREAKPOINT;
          end else begin
            // This cycle commits.
            r_ignora_bp <= 1'b0;
            if (w_eb) begin
              r_estado <= ESTADO_PARADO;
              r_parado <= 1'b1;
              r_causa  <= CAUSA_EBREAK;
            end else if ((r_estado == ESTADO_PASSO) && w_ultimo) begin
              r_estado <= ESTADO_PARADO;
              r_parado <= 1'b1;
              r_causa  <= CAUSA_FIM_PASSO;
            end
          end
        end

        default: begin
          r_estado <= ESTADO_PARADO;
          r_parado <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr_retiradas <= '0;
    end else if (w_habilita) begin
      r_instr_retiradas <= r_instr_retiradas + LARGURA_CONT'(1);
    end
  end

  assign habilita        = w_habilita;
  assign parado          = r_parado;
  assign causa           = r_causa;
  assign instr_retiradas = r_instr_retiradas;

endmodule
`default_nettype wire

// File: tb/tb_controle_execucao.sv
`default_nettype none
// ============================================================================
// Module   : tb_controle_execucao
// Purpose  : Self-checking bench for controle_execucao. Instance A uses the
//            default parameters; instance B has EBREAK halting disabled,
//            starts running out of reset and has a 4-bit retired counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controle_execucao;

  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam int M_STOP = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_run = 1'b0, cmd_halt = 1'b0, cmd_step = 1'b0;
  logic [15:0] passos = 16'd0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'd0, atualPC = 32'd0, inst = NOP;

  logic        hab_a, par_a, hab_b, par_b;
  logic [2:0]  cau_a, cau_b;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  controle_execucao #(.LARGURA_CONT(32), .PARAR_EBREAK(1'b1), .INICIA_EXECUTANDO(1'b0)) dut_a (
    .clk(clk), .rst(rst), .cmd_run(cmd_run), .cmd_halt(cmd_halt), .cmd_step(cmd_step),
    .passos(passos), .bp_en(bp_en), .bp_addr(bp_addr), .atualPC(atualPC), .inst(inst),
    .habilita(hab_a), .parado(par_a), .causa(cau_a), .instr_retiradas(cnt_a));

  controle_execucao #(.LARGURA_CONT(4), .PARAR_EBREAK(1'b0), .INICIA_EXECUTANDO(1'b1)) dut_b (
    .clk(clk), .rst(rst), .cmd_run(cmd_run), .cmd_halt(cmd_halt), .cmd_step(cmd_step),
    .passos(passos), .bp_en(bp_en), .bp_addr(bp_addr), .atualPC(atualPC), .inst(inst),
    .habilita(hab_b), .parado(par_b), .causa(cau_b), .instr_retiradas(cnt_b));

  // ---------------- behavioural reference model (one per instance) --------
  bit     p_eb  [2] = '{1'b1, 1'b0};
  bit     p_ini [2] = '{1'b0, 1'b1};
  longint p_mod [2] = '{64'd4294967296, 64'd16};

  int     m_mode  [2];
  int     m_left  [2];
  bit     m_skip  [2];
  int     m_cause [2];
  longint m_cnt   [2];

  function automatic void model_reset(input int k);
    m_mode[k]  = p_ini[k] ? M_RUN : M_STOP;
    m_left[k]  = 0;
    m_skip[k]  = 1'b0;
    m_cause[k] = 0;
    m_cnt[k]   = 0;
  endfunction

  function automatic bit exp_hab(input int k);
    bit hit = bp_en && (atualPC == bp_addr) && !m_skip[k];
    return !rst && (m_mode[k] != M_STOP) && !cmd_halt && !hit;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        model_reset(k);
      end else if (m_mode[k] == M_STOP) begin
        if (!cmd_halt && cmd_step) begin
          m_mode[k] = M_STEP;
          m_left[k] = (passos == 16'd0) ? 1 : int'(passos);
          m_skip[k] = 1'b1;
        end else if (!cmd_halt && cmd_run) begin
          m_mode[k] = M_RUN;
          m_skip[k] = 1'b1;
        end
      end else if (cmd_halt) begin
        m_mode[k] = M_STOP; m_cause[k] = 1;
      end else if (!exp_hab(k)) begin
        m_mode[k] = M_STOP; m_cause[k] = 2;
      end else begin
        m_cnt[k]  = (m_cnt[k] + 1) % p_mod[k];
        m_skip[k] = 1'b0;
        if (m_mode[k] == M_STEP) m_left[k] = m_left[k] - 1;
        if (p_eb[k] && inst == EBREAK) begin
          m_mode[k] = M_STOP; m_cause[k] = 4;
        end else if (m_mode[k] == M_STEP && m_left[k] == 0) begin
          m_mode[k] = M_STOP; m_cause[k] = 3;
        end
      end
    end
  end

  // --------------------------------------------------------------- tests ----
  task automatic test_reset();
    #2 rst = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (par_a !== 1'b1) begin n_fail++; $display("FAIL reset_parado: observed %0h required 1", par_a); end
    n_cmp++; if (hab_a !== 1'b0) begin n_fail++; $display("FAIL reset_habilita: observed %0h required 0", hab_a); end
    n_cmp++; if (cau_a !== 3'd0) begin n_fail++; $display("FAIL reset_causa: observed %0h required 0", cau_a); end
    n_cmp++; if (cnt_a !== 32'd0) begin n_fail++; $display("FAIL reset_count: observed %0h required 0", cnt_a); end
    n_cmp++; if (hab_b !== 1'b0) begin n_fail++; $display("FAIL reset_habilita_run: observed %0h required 0", hab_b); end
    n_cmp++; if (par_b !== 1'b0) begin n_fail++; $display("FAIL reset_parado_run: observed %0h required 0", par_b); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++; if (hab_a !== 1'b0) begin n_fail++; $display("FAIL idle_habilita: observed %0h required 0", hab_a); end
    end
  endtask

  task automatic test_breakpoint();
    @(negedge clk); bp_en = 1'b1; bp_addr = 32'h0C; atualPC = 32'h0; cmd_run = 1'b1; #1;
    n_cmp++; if (hab_a !== 1'b0) begin n_fail++; $display("FAIL bp_run_cycle: observed %0h required 0", hab_a); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); cmd_run = 1'b0; atualPC = 32'(4 * i); #1;
      n_cmp++; if (hab_a !== 1'b1) begin n_fail++; $display("FAIL bp_commit pc=%0h: observed %0h required 1", atualPC, hab_a); end
    end
    @(negedge clk); atualPC = 32'h0C; #1;
    n_cmp++; if (hab_a !== 1'b0) begin n_fail++; $display("FAIL bp_hit_habilita: observed %0h required 0", hab_a); end
    @(negedge clk); #1;
    n_cmp++; if (par_a !== 1'b1) begin n_fail++; $display("FAIL bp_parado: observed %0h required 1", par_a); end
    n_cmp++; if (cau_a !== 3'd2) begin n_fail++; $display("FAIL bp_causa: observed %0h required 2", cau_a); end
    n_cmp++; if (cnt_a !== 32'd3) begin n_fail++; $display("FAIL bp_count: observed %0h required 3", cnt_a); end
  endtask

  task automatic test_resume();
    @(negedge clk); cmd_run = 1'b1; #1;
    @(negedge clk); cmd_run = 1'b0; #1;
    n_cmp++; if (hab_a !== 1'b1) begin n_fail++; $display("FAIL resume_at_bp: observed %0h required 1", hab_a); end
    @(negedge clk); atualPC = 32'h10; #1;
    n_cmp++; if (hab_a !== 1'b1) begin n_fail++; $display("FAIL resume_next: observed %0h required 1", hab_a); end
    @(negedge clk); atualPC = 32'h0C; #1;
    n_cmp++; if (hab_a !== 1'b0) begin n_fail++; $display("FAIL rearm_habilita: observed %0h required 0", hab_a); end
    @(negedge clk); #1;
    n_cmp++; if (par_a !== 1'b1) begin n_fail++; $display("FAIL rearm_parado: observed %0h required 1", par_a); end
    n_cmp++; if (cau_a !== 3'd2) begin n_fail++; $display("FAIL rearm_causa: observed %0h required 2", cau_a); end
    n_cmp++; if (cnt_a !== 32'd5) begin n_fail++; $display("FAIL rearm_count: observed %0h required 5", cnt_a); end
  endtask

  task automatic test_step(input logic [15:0] pedido, input int commits);
    logic [31:0] base;
    @(negedge clk); bp_en = 1'b0; atualPC = 32'h20; passos = pedido; cmd_step = 1'b1; #1;
    base = cnt_a;
    n_cmp++; if (hab_a !== 1'b0) begin n_fail++; $display("FAIL step_cmd_cycle: observed %0h required 0", hab_a); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); cmd_step = 1'b0; atualPC = atualPC + 32'd4; #1;
      n_cmp++; if (hab_a !== (i < commits)) begin
        n_fail++; $display("FAIL step_habilita n=%0d i=%0d: observed %0h required %0h", pedido, i, hab_a, (i < commits));
      end
    end
    n_cmp++; if (par_a !== 1'b1) begin n_fail++; $display("FAIL step_parado: observed %0h required 1", par_a); end
    n_cmp++; if (cau_a !== 3'd3) begin n_fail++; $display("FAIL step_causa: observed %0h required 3", cau_a); end
    n_cmp++; if (cnt_a !== base + 32'(commits)) begin n_fail++; $display("FAIL step_count: observed %0h required %0h", cnt_a, base + 32'(commits)); end
  endtask

  task automatic test_ebreak();
    @(negedge clk); bp_en = 1'b0; cmd_halt = 1'b1; #1;
    @(negedge clk); cmd_halt = 1'b0; cmd_run = 1'b1; #1;
    @(negedge clk); cmd_run = 1'b0; atualPC = 32'h0C; inst = NOP; #1;
    n_cmp++; if (hab_a !== 1'b1) begin n_fail++; $display("FAIL eb_pre_commit: observed %0h required 1", hab_a); end
    @(negedge clk); atualPC = 32'h10; inst = EBREAK; #1;
    n_cmp++; if (hab_a !== 1'b1) begin n_fail++; $display("FAIL eb_commit: observed %0h required 1", hab_a); end
    n_cmp++; if (hab_b !== 1'b1) begin n_fail++; $display("FAIL eb_commit_nohalt: observed %0h required 1", hab_b); end
    @(negedge clk); atualPC = 32'h14; inst = NOP; #1;
    n_cmp++; if (par_a !== 1'b1) begin n_fail++; $display("FAIL eb_parado: observed %0h required 1", par_a); end
    n_cmp++; if (cau_a !== 3'd4) begin n_fail++; $display("FAIL eb_causa: observed %0h required 4", cau_a); end
    n_cmp++; if (hab_a !== 1'b0) begin n_fail++; $display("FAIL eb_after: observed %0h required 0", hab_a); end
    n_cmp++; if (par_b !== 1'b0) begin n_fail++; $display("FAIL eb_disabled_parado: observed %0h required 0", par_b); end
    n_cmp++; if (hab_b !== 1'b1) begin n_fail++; $display("FAIL eb_disabled_continue: observed %0h required 1", hab_b); end
  endtask

  task automatic test_halt_run_same();
    @(negedge clk); cmd_halt = 1'b1; cmd_run = 1'b1; #1;
    @(negedge clk); cmd_halt = 1'b0; cmd_run = 1'b0; #1;
    n_cmp++; if (par_a !== 1'b1) begin n_fail++; $display("FAIL halt_run_parado: observed %0h required 1", par_a); end
    n_cmp++; if (hab_a !== 1'b0) begin n_fail++; $display("FAIL halt_run_habilita: observed %0h required 0", hab_a); end
    n_cmp++; if (cau_a !== 3'd4) begin n_fail++; $display("FAIL halt_run_causa_held: observed %0h required 4", cau_a); end
  endtask

  task automatic test_halt_in_step();
    logic [31:0] base;
    @(negedge clk); passos = 16'd5; cmd_step = 1'b1; #1;
    base = cnt_a;
    @(negedge clk); cmd_step = 1'b0; cmd_halt = 1'b1; #1;
    n_cmp++; if (hab_a !== 1'b0) begin n_fail++; $display("FAIL step_halt_habilita: observed %0h required 0", hab_a); end
    @(negedge clk); cmd_halt = 1'b0; #1;
    n_cmp++; if (par_a !== 1'b1) begin n_fail++; $display("FAIL step_halt_parado: observed %0h required 1", par_a); end
    n_cmp++; if (cau_a !== 3'd1) begin n_fail++; $display("FAIL step_halt_causa: observed %0h required 1", cau_a); end
    n_cmp++; if (cnt_a !== base) begin n_fail++; $display("FAIL step_halt_count: observed %0h required %0h", cnt_a, base); end
  endtask

  task automatic test_reset_mid_step();
    @(negedge clk); passos = 16'd5; cmd_step = 1'b1; #1;
    @(negedge clk); cmd_step = 1'b0; #1;
    n_cmp++; if (hab_a !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: observed %0h required 1", hab_a); end
    #1 rst = 1'b1; #1;
    n_cmp++; if (hab_a !== 1'b0) begin n_fail++; $display("FAIL midrst_habilita: observed %0h required 0", hab_a); end
    n_cmp++; if (par_a !== 1'b1) begin n_fail++; $display("FAIL midrst_parado: observed %0h required 1", par_a); end
    n_cmp++; if (cnt_a !== 32'd0) begin n_fail++; $display("FAIL midrst_count: observed %0h required 0", cnt_a); end
    n_cmp++; if (cau_a !== 3'd0) begin n_fail++; $display("FAIL midrst_causa: observed %0h required 0", cau_a); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (hab_a !== 1'b0) begin n_fail++; $display("FAIL midrst_aborted: observed %0h required 0", hab_a); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 299) == 0);
      cmd_run  = ($urandom_range(0, 11) == 0);
      cmd_halt = ($urandom_range(0, 15) == 0);
      cmd_step = ($urandom_range(0, 11) == 0);
      passos   = 16'($urandom_range(0, 4));
      bp_en    = $urandom_range(0, 1) == 1;
      bp_addr  = 32'(4 * $urandom_range(0, 3));
      atualPC  = 32'(4 * $urandom_range(0, 3));
      inst     = ($urandom_range(0, 5) == 0) ? EBREAK : NOP;
      #1;
      n_cmp++; if (hab_a !== exp_hab(0)) begin n_fail++; $display("FAIL rnd_hab_a c=%0d: observed %0h required %0h", c, hab_a, exp_hab(0)); end
      n_cmp++; if (hab_b !== exp_hab(1)) begin n_fail++; $display("FAIL rnd_hab_b c=%0d: observed %0h required %0h", c, hab_b, exp_hab(1)); end
      n_cmp++; if (par_a !== (m_mode[0] == M_STOP)) begin n_fail++; $display("FAIL rnd_par_a c=%0d: observed %0h required %0h", c, par_a, (m_mode[0] == M_STOP)); end
      n_cmp++; if (par_b !== (m_mode[1] == M_STOP)) begin n_fail++; $display("FAIL rnd_par_b c=%0d: observed %0h required %0h", c, par_b, (m_mode[1] == M_STOP)); end
      n_cmp++; if (cau_a !== 3'(m_cause[0])) begin n_fail++; $display("FAIL rnd_causa_a c=%0d: observed %0h required %0h", c, cau_a, m_cause[0]); end
      n_cmp++; if (cau_b !== 3'(m_cause[1])) begin n_fail++; $display("FAIL rnd_causa_b c=%0d: observed %0h required %0h", c, cau_b, m_cause[1]); end
      n_cmp++; if (cnt_a !== 32'(m_cnt[0])) begin n_fail++; $display("FAIL rnd_cnt_a c=%0d: observed %0h required %0h", c, cnt_a, m_cnt[0]); end
      n_cmp++; if (cnt_b !== 4'(m_cnt[1])) begin n_fail++; $display("FAIL rnd_cnt_b c=%0d: observed %0h required %0h", c, cnt_b, m_cnt[1]); end
    end
    @(negedge clk);
    rst = 1'b0; cmd_run = 1'b0; cmd_halt = 1'b0; cmd_step = 1'b0;
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    test_reset();
    test_breakpoint();
    test_resume();
    test_step(16'd2, 2);
    test_step(16'd0, 1);
    test_ebreak();
    test_halt_run_same();
    test_halt_in_step();
    test_reset_mid_step();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
